// File: rtl/mdu_issue_ctrl_if.sv
// MDU request/ready bus between the issue controller (master) and the MDU (slave).
// Signal names follow the controller's point of view.
interface mdu_issue_ctrl_if;
  logic        mdu_en_o;
  logic        mdu_clear_o;
  logic [4:0]  mdu_control_o;
  logic [31:0] mdu_a_o;
  logic [31:0] mdu_b_o;
  logic [63:0] mdu_result_i;
  logic        mdu_ready_i;

  modport master (
    output mdu_en_o,
    output mdu_clear_o,
    output mdu_control_o,
    output mdu_a_o,
    output mdu_b_o,
    input  mdu_result_i,
    input  mdu_ready_i
  );

  modport slave (
    input  mdu_en_o,
    input  mdu_clear_o,
    input  mdu_control_o,
    input  mdu_a_o,
    input  mdu_b_o,
    output mdu_result_i,
    output mdu_ready_i
  );
endinterface

// File: rtl/mdu_issue_ctrl.sv
// Issues MULT/DIV/MTHI/MTLO from EX to the MDU, stalls the pipe until ready, owns HI/LO.
// state | meaning
// IDLE  | accepting ops; multiplies may complete in the issue cycle
// BUSY  | waiting on MDU ready with latched op/operands, pipe stalled
// DONE  | held EX op already completed; wait for stall_i to drop
module mdu_issue_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    op_valid_i,
  input  logic [2:0]              op_i,
  input  logic [31:0]             a_i,
  input  logic [31:0]             b_i,
  input  logic                    flush_i,
  input  logic                    stall_i,
  mdu_issue_ctrl_if.master        mdu,
  output logic                    stall_o,
  output logic [31:0]             hi_o,
  output logic [31:0]             lo_o,
  output logic [7:0]              busy_cnt_o,
  output logic                    err_o
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam logic [4:0] CTRL_MULT  = 5'b11000;
  localparam logic [4:0] CTRL_MULTU = 5'b11001;
  localparam logic [4:0] CTRL_DIV   = 5'b11010;
  localparam logic [4:0] CTRL_DIVU  = 5'b11011;

  function automatic logic [4:0] ctrlOf(input logic [2:0] op);
    case (op)
      OP_MULT:  ctrlOf = CTRL_MULT;
      OP_MULTU: ctrlOf = CTRL_MULTU;
      OP_DIV:   ctrlOf = CTRL_DIV;
      OP_DIVU:  ctrlOf = CTRL_DIVU;
      default:  ctrlOf = 5'd0;
    endcase
  endfunction

  state_t      state;
  logic [2:0]  latOp;
  logic [31:0] latA;
  logic [31:0] latB;

  logic        opIsMd;
  logic        opIsMove;
  logic        start;
  logic        moveWr;
  logic        enComb;
  logic        clearComb;
  logic        stallComb;
  logic [4:0]  ctrlComb;
  logic [31:0] aComb;
  logic [31:0] bComb;
  logic [7:0]  busyCntNext;
  logic        watchdogHit;

  always_comb begin
    opIsMd    = op_i inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
    opIsMove  = (op_i == OP_MTHI) || (op_i == OP_MTLO);
    start     = (state == IDLE) && op_valid_i && opIsMd && !flush_i;
    moveWr    = (state == IDLE) && op_valid_i && opIsMove && !flush_i;
    enComb    = 1'b0;
    clearComb = 1'b0;
    stallComb = 1'b0;
    ctrlComb  = 5'd0;
    aComb     = a_i;
    bComb     = b_i;
    case (state)
      IDLE: begin
        enComb    = start;
        ctrlComb  = start ? ctrlOf(op_i) : 5'd0;
        stallComb = start && !mdu.mdu_ready_i;
      end
      BUSY: begin
        enComb    = 1'b1;
        clearComb = flush_i;
        ctrlComb  = ctrlOf(latOp);
        aComb     = latA;
        bComb     = latB;
        stallComb = !flush_i && !mdu.mdu_ready_i;
      end
      default: ;
    endcase
  end

  // Handshake outputs are forced quiet while reset is asserted, even though IDLE passes through.
  assign mdu.mdu_en_o      = enComb & rst;
  assign mdu.mdu_clear_o   = clearComb & rst;
  assign mdu.mdu_control_o = ctrlComb & {5{rst}};
  assign mdu.mdu_a_o       = aComb;
  assign mdu.mdu_b_o       = bComb;
  assign stall_o           = stallComb & rst;

  assign busyCntNext = (busy_cnt_o == 8'hFF) ? 8'hFF : busy_cnt_o + 8'd1;
  assign watchdogHit = (TIMEOUT_CYCLES != 0) && (32'(busyCntNext) == TIMEOUT_CYCLES);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      hi_o       <= 32'd0;
      lo_o       <= 32'd0;
      latOp      <= 3'd0;
      latA       <= 32'd0;
      latB       <= 32'd0;
      busy_cnt_o <= 8'd0;
      err_o      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (mdu.mdu_ready_i) begin
              hi_o  <= mdu.mdu_result_i[63:32];
              lo_o  <= mdu.mdu_result_i[31:0];
              state <= stall_i ? DONE : IDLE;
            end else begin
              latOp      <= op_i;
              latA       <= a_i;
              latB       <= b_i;
              busy_cnt_o <= 8'd0;
              state      <= BUSY;
            end
          end else if (moveWr) begin
            if (op_i == OP_MTHI) hi_o <= a_i;
            else                 lo_o <= a_i;
            state <= stall_i ? DONE : IDLE;
          end
        end
        BUSY: begin
          busy_cnt_o <= busyCntNext;
          if (watchdogHit) err_o <= 1'b1;
          // Flush beats a same-cycle ready: the result is annulled, not committed.
          if (flush_i) begin
            state <= IDLE;
          end else if (mdu.mdu_ready_i) begin
            hi_o  <= mdu.mdu_result_i[63:32];
            lo_o  <= mdu.mdu_result_i[31:0];
            state <= stall_i ? DONE : IDLE;
          end
        end
        DONE: begin
          if (!stall_i || flush_i) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Directed bench for mdu_issue_ctrl; a monitor checks every HI/LO update against a scoreboard queue.
module tb_mdu_issue_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        op_valid;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        stall_i;
  logic        stall_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic [7:0]  busy_cnt_o;
  logic        err_o;

  mdu_issue_ctrl_if mif();

  always #5 clk = ~clk;

  mdu_issue_ctrl #(.TIMEOUT_CYCLES(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .op_valid_i (op_valid),
    .op_i       (op),
    .a_i        (a),
    .b_i        (b),
    .flush_i    (flush),
    .stall_i    (stall_i),
    .mdu        (mif.master),
    .stall_o    (stall_o),
    .hi_o       (hi_o),
    .lo_o       (lo_o),
    .busy_cnt_o (busy_cnt_o),
    .err_o      (err_o)
  );

  int checks = 0;
  int errors = 0;
  logic [63:0] expQ[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: any change of {HI,LO} must match the next scoreboard entry.
  initial begin
    logic [63:0] prev;
    logic [63:0] cur;
    logic [63:0] e;
    prev = 64'd0;
    forever begin
      @(posedge clk);
      #2;
      cur = {hi_o, lo_o};
      if (!rst) begin
        prev = 64'd0;
      end else if (cur !== prev) begin
        if (expQ.size() == 0) begin
          chk("unexpected_hilo_write", cur, prev);
        end else begin
          e = expQ.pop_front();
          chk("hilo_commit", cur, e);
        end
        prev = cur;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL sim_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int stallCnt;
    op_valid = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0;
    flush = 1'b0; stall_i = 1'b0;
    mif.mdu_ready_i = 1'b0; mif.mdu_result_i = 64'd0;

    // Reset: outputs quiet even with an op presented
    @(negedge clk); op_valid = 1'b1; op = 3'd1; #1;
    chk("rst_en", mif.mdu_en_o, 0);
    chk("rst_clear", mif.mdu_clear_o, 0);
    chk("rst_ctrl", mif.mdu_control_o, 0);
    chk("rst_stall", stall_o, 0);
    chk("rst_hi", hi_o, 0);
    chk("rst_lo", lo_o, 0);
    chk("rst_busy", busy_cnt_o, 0);
    chk("rst_err", err_o, 0);
    @(negedge clk); op_valid = 1'b0; op = 3'd0; rst = 1'b1;

    // MULT completing in the issue cycle
    @(negedge clk);
    op_valid = 1'b1; op = 3'd1; a = 32'hFFFF_FFFE; b = 32'd3;
    mif.mdu_ready_i = 1'b1; mif.mdu_result_i = 64'hFFFF_FFFF_FFFF_FFFA;
    expQ.push_back(64'hFFFF_FFFF_FFFF_FFFA);
    #1;
    chk("mult_en", mif.mdu_en_o, 1);
    chk("mult_ctrl", mif.mdu_control_o, 5'b11000);
    chk("mult_a", mif.mdu_a_o, 32'hFFFF_FFFE);
    chk("mult_b", mif.mdu_b_o, 32'd3);
    chk("mult_stall", stall_o, 0);
    @(negedge clk); op_valid = 1'b0; op = 3'd0; mif.mdu_ready_i = 1'b0; #1;
    chk("mult_hi", hi_o, 32'hFFFF_FFFF);
    chk("mult_lo", lo_o, 32'hFFFF_FFFA);

    // MTHI then MTLO
    @(negedge clk); op_valid = 1'b1; op = 3'd5; a = 32'h1234_5678;
    expQ.push_back({32'h1234_5678, 32'hFFFF_FFFA}); #1;
    chk("mthi_stall", stall_o, 0);
    chk("mthi_en", mif.mdu_en_o, 0);
    @(negedge clk); op = 3'd6; a = 32'h9;
    expQ.push_back({32'h1234_5678, 32'h9}); #1;
    chk("mtlo_stall", stall_o, 0);
    @(negedge clk); op_valid = 1'b0; op = 3'd0; #1;
    chk("mt_hi", hi_o, 32'h1234_5678);
    chk("mt_lo", lo_o, 32'h9);

    // DIV flushed in its fourth BUSY cycle, with ready arriving at the same time
    @(negedge clk); op_valid = 1'b1; op = 3'd3; a = 32'hFFFF_FFCE; b = 32'd7; #1;
    chk("div_issue_stall", stall_o, 1);
    chk("div_ctrl", mif.mdu_control_o, 5'b11010);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk); a = a + 32'd1; b = b + 32'd1; #1;
      chk("div_busy_a", mif.mdu_a_o, 32'hFFFF_FFCE);
      chk("div_busy_stall", stall_o, 1);
    end
    @(negedge clk); flush = 1'b1; op_valid = 1'b0;
    mif.mdu_ready_i = 1'b1; mif.mdu_result_i = 64'h0BAD_0BAD_0BAD_0BAD; #1;
    chk("flush_clear", mif.mdu_clear_o, 1);
    chk("flush_stall", stall_o, 0);
    @(negedge clk); flush = 1'b0; mif.mdu_ready_i = 1'b0; mif.mdu_result_i = 64'd0; #1;
    chk("post_flush_clear", mif.mdu_clear_o, 0);
    chk("post_flush_stall", stall_o, 0);
    chk("post_flush_hi", hi_o, 32'h1234_5678);
    chk("post_flush_lo", lo_o, 32'h9);
    chk("post_flush_err", err_o, 0);

    // MULTU right after the flush
    @(negedge clk); op_valid = 1'b1; op = 3'd2; a = 32'd5; b = 32'd6;
    mif.mdu_ready_i = 1'b1; mif.mdu_result_i = 64'd30;
    expQ.push_back(64'd30); #1;
    chk("multu_en", mif.mdu_en_o, 1);
    chk("multu_ctrl", mif.mdu_control_o, 5'b11001);
    chk("multu_stall", stall_o, 0);
    @(negedge clk); op_valid = 1'b0; op = 3'd0; mif.mdu_ready_i = 1'b0; #1;
    chk("multu_lo", lo_o, 32'd30);

    // MULTU completing under downstream stall; DONE must not re-issue
    @(negedge clk); op_valid = 1'b1; op = 3'd2; a = 32'hFFFF_FFFF; b = 32'd2;
    mif.mdu_ready_i = 1'b1; mif.mdu_result_i = 64'h1_FFFF_FFFE; stall_i = 1'b1;
    expQ.push_back(64'h1_FFFF_FFFE); #1;
    chk("multu_st_en", mif.mdu_en_o, 1);
    chk("multu_st_stall", stall_o, 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); mif.mdu_result_i = 64'hDEAD_BEEF_DEAD_BEEF; #1;
      chk("done_en", mif.mdu_en_o, 0);
      chk("done_stall", stall_o, 0);
    end
    @(negedge clk); stall_i = 1'b0; #1;
    chk("done_release_en", mif.mdu_en_o, 0);
    @(negedge clk); op_valid = 1'b0; op = 3'd0; mif.mdu_ready_i = 1'b0; mif.mdu_result_i = 64'd0; #1;
    chk("multu_st_hi", hi_o, 32'h1);
    chk("multu_st_lo", lo_o, 32'hFFFF_FFFE);

    // DIVU: 11 stalled cycles, operands held while a_i/b_i wander
    @(negedge clk); op_valid = 1'b1; op = 3'd4; a = 32'd100; b = 32'd7;
    expQ.push_back({32'd2, 32'd14}); #1;
    stallCnt = int'(stall_o);
    chk("divu_ctrl", mif.mdu_control_o, 5'b11011);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk); a = a + 32'd13; b = b ^ 32'h55; #1;
      stallCnt += int'(stall_o);
      chk("divu_hold_a", mif.mdu_a_o, 32'd100);
      chk("divu_hold_b", mif.mdu_b_o, 32'd7);
    end
    @(negedge clk); mif.mdu_ready_i = 1'b1; mif.mdu_result_i = {32'd2, 32'd14}; #1;
    stallCnt += int'(stall_o);
    chk("divu_ready_stall", stall_o, 0);
    chk("divu_stall_cycles", stallCnt, 11);
    @(negedge clk); op_valid = 1'b0; op = 3'd0; mif.mdu_ready_i = 1'b0; mif.mdu_result_i = 64'd0; #1;
    chk("divu_hi", hi_o, 32'd2);
    chk("divu_lo", lo_o, 32'd14);
    chk("divu_after_stall", stall_o, 0);
    chk("divu_err_set", err_o, 1);

    @(negedge clk); rst = 1'b0; #1;
    chk("rst2_err", err_o, 0);
    chk("rst2_hi", hi_o, 0);
    chk("rst2_lo", lo_o, 0);
    @(negedge clk); rst = 1'b1;

    // Watchdog: MDU never ready
    @(negedge clk); op_valid = 1'b1; op = 3'd3; a = 32'd1; b = 32'd1; #1;
    chk("wd_issue_stall", stall_o, 1);
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk); #1;
      if (i == 8)   chk("wd_before", err_o, 0);
      if (i == 9)   chk("wd_set", err_o, 1);
      if (i == 9)   chk("wd_cnt", busy_cnt_o, 8);
      if (i == 200) chk("wd_sticky", err_o, 1);
    end
    chk("wd_sat", busy_cnt_o, 8'hFF);
    chk("wd_still_stall", stall_o, 1);
    chk("wd_still_en", mif.mdu_en_o, 1);
    @(negedge clk); rst = 1'b0; #1;
    chk("rst3_busy", busy_cnt_o, 0);
    chk("rst3_err", err_o, 0);
    chk("rst3_stall", stall_o, 0);
    chk("rst3_en", mif.mdu_en_o, 0);
    chk("rst3_clear", mif.mdu_clear_o, 0);
    @(negedge clk); rst = 1'b1; op_valid = 1'b0; op = 3'd0;
    @(negedge clk);
    chk("scoreboard_drained", expQ.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
